alu_responder: RTL

Memory-mapped 256-bit ALU responder on the shared processor bus; it is the slave end of the operand/command/status/result protocol that the execution unit drives. One instance sits at base 'h2000 for the arithmetic unit and one at 'h3000 for the integer/branch unit. It captures two operands and a command word, computes for a fixed number of cycles, raises a done flag, and returns the result on read.

---
 rtl/alu_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_responder.sv
// alu_responder: memory-mapped 256-bit ALU slave on the shared processor bus.
// It captures two operands and a command, computes for LATENCY cycles on a
// snapshot of them, then raises done and returns the result on read.
module alu_responder #(
  parameter logic [15:0] BASE_ADDR = 16'h3000,
  parameter int          LATENCY   = 4
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic [15:0]  address,
  input  logic         nRead,
  input  logic         nWrite,
  inout  wire  [255:0] DataBus
);

  localparam logic [15:0] A_OPA    = BASE_ADDR;
  localparam logic [15:0] A_OPB    = BASE_ADDR + 16'h0001;
  localparam logic [15:0] A_RESULT = BASE_ADDR + 16'h0D00;
  localparam logic [15:0] A_CMD    = BASE_ADDR + 16'h0E00;
  localparam logic [15:0] A_STATUS = BASE_ADDR + 16'h0F00;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [255:0]   opa_q, opa_d;
  logic [255:0]   opb_q, opb_d;
  logic [255:0]   result_q, result_d;
  logic [255:0]   snap_a_q, snap_a_d;
  logic [255:0]   snap_b_q, snap_b_d;
  logic [3:0]     snap_fn_q, snap_fn_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           prev_cmd_q, prev_cmd_d;
  logic           done_q, done_d;

  logic           hit_opa, hit_opb, hit_cmd, hit_status, hit_result;
  logic           cmd_wr, cmd_accept, rd_en;
  logic [255:0]   rd_data;
  logic [255:0]   alu_out;

  // Result of one operation; compares return 1/0, shifts past 255 return 0.
  function automatic logic [255:0] alu_eval(input logic [3:0]   fn,
                                            input logic [255:0] a,
                                            input logic [255:0] b);
    logic signed [255:0] sa;
    logic signed [255:0] sb;
    logic                shift_ok;
    logic [255:0]        r;
    sa       = a;
    sb       = b;
    shift_ok = (b[255:8] == 248'd0);
    case (fn)
      4'h1:    r = a + b;
      4'h2:    r = a - b;
      4'h3:    r = a * b;
      4'h4:    r = a & b;
      4'h5:    r = a | b;
      4'h6:    r = a ^ b;
      4'h7:    r = shift_ok ? (a << b[7:0]) : '0;
      4'h8:    r = shift_ok ? (a >> b[7:0]) : '0;
      4'h9:    r = ~a;
      4'hA:    r = {255'd0, a == b};
      4'hB:    r = {255'd0, a != b};
      4'hC:    r = {255'd0, a <  b};
      4'hD:    r = {255'd0, a >= b};
      4'hE:    r = {255'd0, sa <  sb};
      4'hF:    r = {255'd0, sa >= sb};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign hit_opa    = (address == A_OPA);
  assign hit_opb    = (address == A_OPB);
  assign hit_cmd    = (address == A_CMD);
  assign hit_status = (address == A_STATUS);
  assign hit_result = (address == A_RESULT);

  // A held CMD write counts once; the command must name this unit and the FSM
  // must not be busy.
  assign cmd_wr     = ~nWrite & hit_cmd;
  assign cmd_accept = cmd_wr & ~prev_cmd_q &
                      (DataBus[15:12] == BASE_ADDR[15:12]) &
                      (state_q != S_BUSY);

  assign alu_out = alu_eval(snap_fn_q, snap_a_q, snap_b_q);

  // State, operand, snapshot and result registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
      snap_fn_q  <= '0;
      cnt_q      <= '0;
      prev_cmd_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
      snap_fn_q  <= snap_fn_d;
      cnt_q      <= cnt_d;
      prev_cmd_q <= prev_cmd_d;
      done_q     <= done_d;
    end
  end

  // Next state: DONE accepts commands just like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (cmd_accept) state_d = S_BUSY;
      S_BUSY:         if (cnt_q == 4'd0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Register updates: operand writes, command snapshot, countdown and result.
  always_comb begin
    opa_d      = (~nWrite & hit_opa) ? DataBus : opa_q;
    opb_d      = (~nWrite & hit_opb) ? DataBus : opb_q;
    result_d   = result_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    snap_fn_d  = snap_fn_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    prev_cmd_d = cmd_wr;
    if (cmd_accept) begin
      snap_a_d  = opa_q;
      snap_b_d  = opb_q;
      snap_fn_d = DataBus[11:8];
      cnt_d     = CNT_INIT;
      done_d    = 1'b0;
    end else if (state_q == S_BUSY) begin
      if (cnt_q == 4'd0) begin
        result_d = alu_out;
        done_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // Read mux; the bus is driven only for a pure read of a readable register.
  always_comb begin
    rd_en   = ~nRead & nWrite & (hit_opa | hit_opb | hit_status | hit_result);
    rd_data = '0;
    if (hit_opa)         rd_data = opa_q;
    else if (hit_opb)    rd_data = opb_q;
    else if (hit_status) rd_data = {255'd0, done_q};
    else if (hit_result) rd_data = result_q;
  end

  assign DataBus = rd_en ? rd_data : {256{1'bz}};

endmodule
